// File: rtl/i2s_tx_mono.sv
// ---------------------------------------------------------------------------
// i2s_tx_mono
//
// Purpose: mono I2S transmitter. 16-bit PCM samples from the downsampler are
// queued in a small FIFO. One sample is sent per 32-slot I2S frame, and the
// same word goes out on both the left and right channels. BCLK is divided from
// clk with independent low and high times. Data changes on BCLK falling
// edges, and the MSB is delayed by one slot after each LRCLK transition, as
// standard I2S requires.
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   sample_in        signed 16-bit PCM sample
//   sample_in_valid  single-cycle write strobe for sample_in
//   clear_flags      synchronous clear of overflow/underflow
//   i2s_bclk         bit clock (registered)
//   i2s_lrclk        word select, 0 = left, 1 = right (registered)
//   i2s_sdata        serial data (registered)
//   fifo_level       current FIFO occupancy, 0..FIFO_DEPTH
//   overflow         sticky: a write was dropped while the FIFO was full
//   underflow        sticky: a frame started with the FIFO empty
//
// Build option: define I2S_TX_HOLD_LAST_EN to repeat the previous sample on
// underflow. Without it, an underflowed frame transmits silence (16'h0000).
// ---------------------------------------------------------------------------
module i2s_tx_mono #(
  parameter int BCLK_LOW   = 36,
  parameter int BCLK_HIGH  = 35,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic signed [15:0]              sample_in,
  input  logic                            sample_in_valid,
  input  logic                            clear_flags,
  output logic                            i2s_bclk,
  output logic                            i2s_lrclk,
  output logic                            i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int DATA_W = 16;
  localparam int PERIOD = BCLK_LOW + BCLK_HIGH;
  localparam int CW     = $clog2(PERIOD + 1);
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW     = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CW-1:0] C_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] C_LOW  = CW'(BCLK_LOW);
  localparam logic [LW-1:0] L_FULL = LW'(FIFO_DEPTH);

  // Timing state
  logic [CW-1:0]            c_q, c_d;
  logic [4:0]               s_q, s_d;
  // Word currently being shifted out
  logic signed [DATA_W-1:0] cur_q, cur_d;
  // FIFO control
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]            level_q, level_d;
  // Registered outputs
  logic                     bclk_q, bclk_d;
  logic                     lrclk_q, lrclk_d;
  logic                     sdata_q, sdata_d;
  logic                     ovf_q, ovf_d;
  logic                     unf_q, unf_d;
  // FIFO storage (data only, not reset)
  logic signed [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic                     fall_evt;
  logic                     pop_evt;
  logic                     pop_ok;
  logic                     wr_ok;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [3:0]               bit_idx;

  always_comb begin
    fall_evt   = (c_q == C_LAST);
    c_d        = fall_evt ? '0 : c_q + CW'(1);
    s_d        = fall_evt ? s_q + 5'd1 : s_q;

    // A new word is fetched on the falling edge that enters slot 1.
    pop_evt    = fall_evt && (s_q == 5'd0);
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == L_FULL);
    pop_ok     = pop_evt && !fifo_empty;
    // Full and empty are judged on the pre-cycle state. A pop in the same
    // cycle frees a slot on a full FIFO, but a write never bypasses into an
    // empty FIFO's pop.
    wr_ok      = sample_in_valid && (!fifo_full || pop_ok);

    cur_d      = cur_q;
    if (pop_ok) begin
      cur_d = mem_q[rd_ptr_q];
    end else if (pop_evt) begin
`ifdef I2S_TX_HOLD_LAST_EN
      cur_d = cur_q;
`else
      cur_d = '0;
`endif
    end

    rd_ptr_d = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = wr_ok  ? wr_ptr_q + PW'(1) : wr_ptr_q;

    level_d = level_q;
    unique case ({wr_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A flag that is set in the same cycle as clear_flags stays set.
    ovf_d = (sample_in_valid && !wr_ok) || (ovf_q && !clear_flags);
    unf_d = (pop_evt && !pop_ok)        || (unf_q && !clear_flags);

    // (16 - s) mod 16 is the 4-bit two's complement of s. This places the
    // MSB at slots 1 and 17 and the LSB at slots 16 and 0.
    bit_idx = 4'd0 - s_d[3:0];
    sdata_d = cur_d[bit_idx];
    bclk_d  = (c_d >= C_LOW);
    lrclk_d = s_d[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q      <= '0;
      s_q      <= '0;
      cur_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      c_q      <= c_d;
      s_q      <= s_d;
      cur_q    <= cur_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      bclk_q   <= bclk_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= sample_in;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule
